// File: rtl/ofm_word_packer_if.sv
// ============================================================================
// Module   : ofm_word_packer_if
// Purpose  : Pixel-stream and OFM write-side signal bundle for ofm_word_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ofm_word_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AXI_WIDTH  = 256
);
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_last;
  logic                  pix_ready;
  logic                  fifo_full;
  logic [AXI_WIDTH-1:0]  WDATA_OUT;
  logic                  write;

  modport master (
    output pix_valid, pix_data, pix_last, fifo_full,
    input  pix_ready, WDATA_OUT, write
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, fifo_full,
    output pix_ready, WDATA_OUT, write
  );
endinterface

`default_nettype wire

// File: rtl/ofm_word_packer.sv
// ============================================================================
// Module   : ofm_word_packer
// Purpose  : Packs 16-bit OFM pixels into AXI-width words, flushes a
//            zero-padded partial word at layer end and pulses layer_done.
//            Optional macro OFM_PACKER_RELU_EN clamps negative pixels to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_word_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int AXI_WIDTH  = 256,
  parameter int CNT_WIDTH  = 20
) (
  input  wire logic                 ACLK,
  input  wire logic                 ARESET,
  ofm_word_packer_if.slave          bus,
  output logic [CNT_WIDTH-1:0]      words_written,
  output logic                      layer_done,
  output logic                      busy
);

  localparam int c_LANES  = AXI_WIDTH / DATA_WIDTH;
  localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_LANE_W-1:0]   r_lane;
  logic [AXI_WIDTH-1:0]  r_word;
  logic                  r_last_flag;
  logic [CNT_WIDTH-1:0]  r_words_written;
  logic                  r_pix_ready;
  logic                  r_layer_done;
  logic                  r_clr_count;

  logic                  w_accept;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_pix_store;

  assign w_accept = bus.pix_valid && r_pix_ready;
  assign w_write  = (r_state == S_EMIT) && !bus.fifo_full;

`ifdef OFM_PACKER_RELU_EN
  assign w_pix_store = bus.pix_data[DATA_WIDTH-1] ? '0 : bus.pix_data;
`else
  assign w_pix_store = bus.pix_data;
`endif

  // r_clr_count defers the counter clear to the next layer's first pixel so
  // the final count stays visible after layer_done.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state         <= S_FILL;
      r_lane          <= '0;
      r_word          <= '0;
      r_last_flag     <= 1'b0;
      r_words_written <= '0;
      r_pix_ready     <= 1'b0;
      r_layer_done    <= 1'b0;
      r_clr_count     <= 1'b0;
    end else begin
      r_layer_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          r_pix_ready <= 1'b1;
          if (w_accept) begin
            r_word[r_lane*DATA_WIDTH +: DATA_WIDTH] <= w_pix_store;
            if (r_clr_count) begin
              r_words_written <= '0;
              r_clr_count     <= 1'b0;
            end
            if ((r_lane == c_LAST_LANE) || bus.pix_last) begin
              r_state     <= S_EMIT;
              r_lane      <= '0;
              r_last_flag <= bus.pix_last;
              r_pix_ready <= 1'b0;
            end else begin
              r_lane <= r_lane + c_LANE_W'(1);
            end
          end
        end

        S_EMIT: begin
          if (w_write) begin
            r_words_written <= r_words_written + CNT_WIDTH'(1);
            r_word          <= '0;
            if (r_last_flag) begin
              r_state      <= S_DONE;
              r_layer_done <= 1'b1;
            end else begin
              r_state     <= S_FILL;
              r_pix_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_last_flag <= 1'b0;
          r_clr_count <= 1'b1;
          r_state     <= S_FILL;
          r_pix_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_FILL;
          r_lane      <= '0;
          r_last_flag <= 1'b0;
          r_pix_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready  = r_pix_ready;
  assign bus.WDATA_OUT  = r_word;
  assign bus.write      = w_write;
  assign words_written  = r_words_written;
  assign layer_done     = r_layer_done;
  assign busy           = (r_lane != '0) || (r_state != S_FILL);

endmodule

`default_nettype wire

// File: tb/tb_ofm_word_packer.sv
// ============================================================================
// Module   : tb_ofm_word_packer
// Purpose  : Scoreboard bench for ofm_word_packer (honours OFM_PACKER_RELU_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofm_word_packer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [19:0] ww;
  logic        layer_done;
  logic        busy;

  ofm_word_packer_if #(.DATA_WIDTH(16), .AXI_WIDTH(256)) bus ();

  ofm_word_packer #(.DATA_WIDTH(16), .AXI_WIDTH(256), .CNT_WIDTH(20)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .bus           (bus.slave),
    .words_written (ww),
    .layer_done    (layer_done),
    .busy          (busy)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] data;
    int           idx;
    bit           last;
  } exp_t;

  exp_t        exp_q[$];
  int          wr_cycles[$];
  logic [15:0] lay[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          full_mode = 0;  // 0 never full, 1 random, 2 always full
  bit          gaps_en = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_pix(input logic [15:0] p);
`ifdef OFM_PACKER_RELU_EN
    return p[15] ? 16'h0000 : p;
`else
    return p;
`endif
  endfunction

  task automatic monitor_loop();
    exp_t e;
    bit   pend = 0;
    bit   chk_low = 0;
    int   pend_total = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        pend = 0;
        chk_low = 0;
      end else begin
        if (pend) begin
          chk("layer_done_pulse", 256'(layer_done), 256'(1));
          chk("words_written_final", 256'(ww), 256'(pend_total));
          pend = 0;
          chk_low = 1;
        end else if (chk_low) begin
          chk("layer_done_single_cycle", 256'(layer_done), 256'(0));
          chk_low = 0;
        end else if (layer_done) begin
          chk("layer_done_unexpected", 256'(layer_done), 256'(0));
        end
        if (bus.write) begin
          wr_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 256'(bus.write), 256'(0));
          end else begin
            e = exp_q.pop_front();
            chk("wdata", bus.WDATA_OUT, e.data);
            chk("words_written_at_write", 256'(ww), 256'(e.idx));
            if (e.last) begin
              pend = 1;
              pend_total = e.idx + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic fifo_loop();
    forever begin
      @(posedge ACLK);
      #2;
      case (full_mode)
        0:       bus.fifo_full = 1'b0;
        1:       bus.fifo_full = ($urandom_range(0, 2) == 0);
        default: bus.fifo_full = 1'b1;
      endcase
    end
  endtask

  // Entered and left on a falling edge; returns just after the accepting edge.
  task automatic drive_pixel(input logic [15:0] d, input bit last);
    int guard = 0;
    while (gaps_en && $urandom_range(0, 3) == 0) begin
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'($urandom);
      bus.pix_data  = 16'($urandom);
      @(negedge ACLK);
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_last  = last;
    while (!bus.pix_ready && guard < 300) begin
      @(negedge ACLK);
      guard++;
    end
    if (guard >= 300) chk("pix_ready_timeout", 256'(bus.pix_ready), 256'(1));
    @(negedge ACLK);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic send_layer(input bit chk_first);
    logic [255:0] w = '0;
    int           nw = 0;
    exp_t         e;
    int           n = lay.size();
    for (int i = 0; i < n; i++) begin
      w[(i % 16) * 16 +: 16] = model_pix(lay[i]);
      if ((i % 16) == 15 || i == n - 1) begin
        e.data = w;
        e.idx  = nw;
        e.last = (i == n - 1);
        exp_q.push_back(e);
        nw++;
        w = '0;
      end
    end
    for (int i = 0; i < n; i++) begin
      drive_pixel(lay[i], i == n - 1);
      if (chk_first && i == 0) chk("words_written_cleared", 256'(ww), 256'(0));
      if (full_mode == 0 && ((i % 16) == 15 || i == n - 1))
        chk("write_latency", 256'(bus.write), 256'(1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  initial begin
    int c0;
    int nw0;
    int guard;
    ARESET        = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    bus.fifo_full = 1'b0;
    fork
      monitor_loop();
      fifo_loop();
    join_none
    idle(2);
    chk("reset_pix_ready", 256'(bus.pix_ready), 256'(0));
    chk("reset_write", 256'(bus.write), 256'(0));
    chk("reset_wdata", bus.WDATA_OUT, 256'(0));
    chk("reset_layer_done", 256'(layer_done), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_words_written", 256'(ww), 256'(0));
    ARESET = 1'b0;

    // Full word of 1..16
    lay.delete();
    for (int i = 1; i <= 16; i++) lay.push_back(16'(i));
    send_layer(0);
    idle(3);

    // Back-pressure while the word waits to be written
    full_mode = 2;
    lay.delete();
    for (int i = 0; i < 16; i++) lay.push_back(16'($urandom));
    send_layer(0);
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge ACLK);
      chk("stall_write", 256'(bus.write), 256'(0));
      chk("stall_pix_ready", 256'(bus.pix_ready), 256'(0));
      if (exp_q.size() > 0) chk("stall_wdata", bus.WDATA_OUT, exp_q[0].data);
    end
    nw0 = wr_cycles.size();
    full_mode = 0;
    guard = 0;
    while (wr_cycles.size() == nw0 && guard < 20) begin
      @(negedge ACLK);
      #1;
      guard++;
    end
    chk("stall_release_write_seen", 256'(wr_cycles.size() > nw0), 256'(1));
    if (wr_cycles.size() > nw0) chk("stall_release_cycle", 256'(wr_cycles[$] - c0), 256'(3));
    idle(3);

    // Partial word discarded by reset
    for (int i = 0; i < 7; i++) drive_pixel(16'($urandom), 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midword_reset_busy", 256'(busy), 256'(0));
    chk("midword_reset_words", 256'(ww), 256'(0));
    chk("midword_reset_write", 256'(bus.write), 256'(0));
    ARESET = 1'b0;
    lay.delete();
    for (int i = 0; i < 16; i++) lay.push_back(16'($urandom));
    send_layer(0);
    idle(1);

    // 48 back-to-back pixels, three words at 17-cycle spacing
    wr_cycles.delete();
    lay.delete();
    for (int i = 0; i < 48; i++) lay.push_back(16'($urandom));
    send_layer(0);
    idle(3);
    chk("b2b_write_count", 256'(wr_cycles.size()), 256'(3));
    if (wr_cycles.size() == 3) begin
      chk("b2b_spacing_1", 256'(wr_cycles[1] - wr_cycles[0]), 256'(17));
      chk("b2b_spacing_2", 256'(wr_cycles[2] - wr_cycles[1]), 256'(17));
    end
    chk("b2b_words_written", 256'(ww), 256'(3));
    chk("b2b_idle_busy", 256'(busy), 256'(0));

    // Five-pixel layer, first accept clears the counter
    lay.delete();
    for (int i = 0; i < 5; i++) lay.push_back(16'h00A0 + 16'(i));
    send_layer(1);
    idle(3);

    // Sign handling
    lay.delete();
    lay.push_back(16'hFFFF);
    lay.push_back(16'h7FFF);
    send_layer(0);
    idle(3);

    // Randomised layers with idle gaps and FIFO back-pressure
    gaps_en   = 1;
    full_mode = 1;
    for (int l = 0; l < 25; l++) begin
      lay.delete();
      for (int i = 0; i < $urandom_range(1, 50); i++) lay.push_back(16'($urandom));
      send_layer(l[0]);
    end
    full_mode = 0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge ACLK);
      guard++;
    end
    chk("drain_scoreboard", 256'(exp_q.size()), 256'(0));
    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofm_word_packer.md
Name: ofm_word_packer

Overview:
- Sits directly upstream of the AXI master's OFM write path.
- Takes the 16-bit output pixel stream from the CNN datapath and packs 16 pixels into one 256-bit word.
- Drives the master's WDATA_IN / write pair and honours the OFM FIFO full flag.
- Closes each layer by emitting a zero-padded partial word, then pulses a layer-done flag.

Parameters:
- DATA_WIDTH, 16: width of one output pixel.
- AXI_WIDTH, 256: packed word width; must equal the master's AXI data width.
- CNT_WIDTH, 20: width of the per-layer written-word counter.
- Derived, not overridable: LANES = AXI_WIDTH/DATA_WIDTH (16); LANE_W = $clog2(LANES).

Ports:
- ACLK  input  1  system clock; all state updates on its rising edge.
- ARESET  input  1  reset, asynchronous assert, active-high.
- pix_valid  input  1  pixel present on pix_data.
- pix_data  input  DATA_WIDTH  output pixel, two's complement.
- pix_last  input  1  qualifies the final pixel of the layer.
- pix_ready  output  1  packer accepts a pixel this cycle.
- fifo_full  input  1  OFM FIFO full; blocks write.
- WDATA_OUT  output  AXI_WIDTH  packed word to the master's WDATA_IN.
- write  output  1  one-cycle FIFO write strobe per word.
- words_written  output  CNT_WIDTH  words written in the current layer.
- layer_done  output  1  single-cycle pulse when a layer is fully flushed.
- busy  output  1  partial word held, or word/flush pending.

Behaviour:
- Reset (ARESET=1, async): state=FILL, lane=0, word register=0, last_flag=0, words_written=0. Outputs: pix_ready=0, write=0, WDATA_OUT=0, layer_done=0, busy=0. A partial word is discarded; there is no flush on reset.
- Accept: a pixel is accepted when pix_valid && pix_ready. Lane L occupies WDATA bits [L*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the LSB; lane increments per accepted pixel.
- FILL state: pix_ready=1.
  - Accept at lane==LANES-1, or accept with pix_last=1 → next state EMIT, lane←0, last_flag←pix_last.
  - Unfilled lanes stay 0, so partial words are zero-padded.
- EMIT state: pix_ready=0. write = !fifo_full (combinational). WDATA_OUT is the word register and is stable throughout EMIT.
  - On write=1: words_written+1, word register cleared.
  - Next state is DONE if last_flag, else FILL.
  - fifo_full=1 holds EMIT indefinitely with no data change.
- DONE state (one cycle): layer_done=1, pix_ready=0, last_flag←0, then FILL. words_written holds its final value until the first accepted pixel of the next layer, which resets it to 0 in the same cycle.
- Latency: the 16th pixel is accepted in cycle N; write is asserted in N+1 at the earliest. Sustained throughput is 16 pixels per 17 cycles.
- busy = (lane!=0) || (state!=FILL).
- words_written wraps modulo 2^CNT_WIDTH with no saturation.
- Ignored cases:
  - pix_valid while pix_ready=0: no effect, because the upstream holds the pixel.
  - pix_last without pix_valid: ignored.
- Illegal state encodings recover to FILL.

Optional Feature:
- Macro OFM_PACKER_RELU_EN.
- Defined: an accepted pixel with pix_data[DATA_WIDTH-1]=1 is stored as 0; non-negative values pass unchanged. No added latency.
- Undefined: pixels are stored bit-exact.

Test Plan:
- 16 pixels 0x0001..0x0010, pix_last on the 16th → one write the cycle after; WDATA_OUT[15:0]=0x0001, [255:240]=0x0010; words_written=1; layer_done one cycle after write.
- 5 pixels 0x00A0..0x00A4, pix_last on the 5th → write with lanes 0-4 populated and bits [255:80]=0; layer_done=1 for exactly one cycle.
- fifo_full=1 for 3 cycles entering EMIT → write=0 and pix_ready=0 for 3 cycles, WDATA_OUT unchanged; write=1 in the 4th cycle.
- 7 pixels accepted, then ARESET pulse → no write, busy=0, words_written=0; the next 16 pixels start at lane 0 and produce exactly one word.
- 48 pixels back-to-back, pix_last on the 48th → exactly 3 writes at 17-cycle spacing; words_written=3; next-layer first accept resets it to 0.
- pix_data=0xFFFF then 0x7FFF → lanes 0/1 = 0x0000/0x7FFF with OFM_PACKER_RELU_EN, 0xFFFF/0x7FFF without.
